// File: rtl/pc_seq_if.sv
// pc_seq_if -- bundle of the fetch-side control and status signals of the
// program-counter sequencer.
//
//   master : the fetch/decode side that drives the decision inputs and
//            observes the PC and RAS status.
//   slave  : the sequencer itself.
//
// Signals
//   stall, hlt, branch, cond[2:0], addr_src, imm[IMM_W-1:0],
//   reg_target[AW-1:0], Z, N, V, call, ret          : master -> slave
//   pc_out[AW-1:0], pc_plus[AW-1:0], redirect,
//   halted, ras_empty, ras_full                      : slave -> master
interface pc_seq_if #(
  parameter int AW    = 16,
  parameter int IMM_W = 9
);
  logic             stall;
  logic             hlt;
  logic             branch;
  logic [2:0]       cond;
  logic             addr_src;
  logic [IMM_W-1:0] imm;
  logic [AW-1:0]    reg_target;
  logic             Z;
  logic             N;
  logic             V;
  logic             call;
  logic             ret;
  logic [AW-1:0]    pc_out;
  logic [AW-1:0]    pc_plus;
  logic             redirect;
  logic             halted;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, hlt, branch, cond, addr_src, imm, reg_target,
    output Z, N, V, call, ret,
    input  pc_out, pc_plus, redirect, halted, ras_empty, ras_full
  );

  modport slave (
    input  stall, hlt, branch, cond, addr_src, imm, reg_target,
    input  Z, N, V, call, ret,
    output pc_out, pc_plus, redirect, halted, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_seq.sv
// pc_seq -- program-counter sequencer at the front of fetch.
//
// Each cycle the next PC is chosen from (highest priority first):
//   hold (halted or stall), hold-and-halt (hlt), return (RAS pop, or
//   reg_target when the RAS is empty), taken branch (reg_target or
//   pc_plus + 2*imm), and finally pc_plus. Taken calls push pc_plus onto a
//   circular return-address stack; a push while full overwrites the oldest
//   entry.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (PC = 0, not halted, RAS empty)
//   bus  : pc_seq_if.slave -- decision inputs and PC/RAS status outputs
//          pc_out   registered current PC
//          pc_plus  pc_out + 2 (combinational)
//          redirect next PC comes from a return or a taken branch (flush)
//          halted   sticky halt, cleared only by rst
//          ras_empty / ras_full  RAS occupancy flags
module pc_seq #(
  parameter int AW        = 16,
  parameter int IMM_W     = 9,
  parameter int RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_seq_if.slave  bus
);

  localparam int PW = $clog2(RAS_DEPTH);      // RAS pointer width
  localparam int CW = $clog2(RAS_DEPTH + 1);  // count 0..RAS_DEPTH

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [AW-1:0]   pc_reg;
  logic [AW-1:0]   pc_next;
  logic [PW-1:0]   top_reg;
  logic [PW-1:0]   top_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;

  logic [AW-1:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [AW-1:0]   ras_top;

  logic [AW-1:0]   pc_plus;
  logic [AW-1:0]   imm_ext;
  logic [AW-1:0]   offset_target;
  logic            cond_true;
  logic            taken;
  logic            ras_empty;
  logic            ras_full;
  logic            push;
  logic            pop;
  logic            redirect;

  // --------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------
  assign pc_plus = pc_reg + AW'(2);

  // imm counts halfwords; sign-extend to AW, then scale to bytes. The add
  // wraps modulo 2^AW on purpose.
  assign imm_ext       = AW'($signed(bus.imm));
  assign offset_target = pc_plus + (imm_ext << 1);

  always_comb begin
    cond_true = 1'b0;
    unique case (bus.cond)
      3'b000:  cond_true = ~bus.Z;
      3'b001:  cond_true = bus.Z;
      3'b010:  cond_true = ~bus.Z & ~bus.N;
      3'b011:  cond_true = bus.N;
      3'b100:  cond_true = bus.Z | ~bus.N;
      3'b101:  cond_true = bus.N | bus.Z;
      3'b110:  cond_true = bus.V;
      3'b111:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign taken = bus.branch & cond_true;

  // --------------------------------------------------------------------
  // Return-address stack
  // top_reg points at the most recent entry; a push writes one slot above
  // it, so a full stack silently overwrites the oldest entry.
  // --------------------------------------------------------------------
  assign ras_empty = (count_reg == '0);
  assign ras_full  = (count_reg == CW'(RAS_DEPTH));
  assign wr_ptr    = top_reg + PW'(1);
  assign ras_top   = ras_mem[top_reg];

  // Entry storage carries no reset; contents are meaningless while the
  // count says they are not live.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[wr_ptr] <= pc_plus;
    end
  end

  always_comb begin
    top_next   = top_reg;
    count_next = count_reg;
    if (push) begin
      top_next = wr_ptr;
      if (!ras_full) begin
        count_next = count_reg + CW'(1);
      end
    end else if (pop) begin
      top_next   = top_reg - PW'(1);
      count_next = count_reg - CW'(1);
    end
  end

  // --------------------------------------------------------------------
  // Run/halt control and next-PC selection
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    redirect   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;

    if (state_reg == ST_HALT || bus.stall) begin
      // hold everything; a hlt seen under stall is deliberately dropped
    end else if (bus.hlt) begin
      state_next = ST_HALT;
    end else if (bus.ret) begin
      // ret wins over call, so a simultaneous call never pushes
      redirect = 1'b1;
      if (!ras_empty) begin
        pop     = 1'b1;
        pc_next = ras_top;
      end else begin
        pc_next = bus.reg_target;
      end
    end else if (taken) begin
      redirect = 1'b1;
      push     = bus.call;
      pc_next  = bus.addr_src ? bus.reg_target : offset_target;
    end else begin
      pc_next = pc_plus;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RUN;
      pc_reg    <= '0;
      top_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      top_reg   <= top_next;
      count_reg <= count_next;
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign bus.pc_out    = pc_reg;
  assign bus.pc_plus   = pc_plus;
  assign bus.redirect  = redirect;
  assign bus.halted    = (state_reg == ST_HALT);
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq -- scoreboard bench for pc_seq. The stimulus process drives one
// decision per cycle on the falling edge and pushes the expected response,
// computed by a behavioural model (PC as an integer, RAS as a queue). A
// separate monitor pops each expectation and compares the DUT outputs.
module tb_pc_seq;

  localparam int AW    = 16;
  localparam int IMM_W = 9;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  pc_seq_if #(.AW(AW), .IMM_W(IMM_W)) bus ();

  pc_seq #(.AW(AW), .IMM_W(IMM_W), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_rst;
    int          id;
    logic [15:0] pc_plus;
    logic        redirect;
    logic [15:0] pc;
    logic        halted;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;

  // behavioural model state
  int          m_pc;
  bit          m_halted;
  logic [15:0] m_ras[$];

  function automatic bit cond_ok(input logic [2:0] c, input logic z, input logic n,
                                 input logic v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic set_idle();
    bus.stall = 0; bus.hlt = 0; bus.branch = 0; bus.cond = 0; bus.addr_src = 0;
    bus.imm = 0; bus.reg_target = 0; bus.Z = 0; bus.N = 0; bus.V = 0;
    bus.call = 0; bus.ret = 0;
  endtask

  // Drive one cycle's decision and record what must come out of it.
  task automatic cycle(input logic stall, input logic hlt, input logic branch,
                       input logic [2:0] cond, input logic addr_src,
                       input logic [8:0] imm, input logic [15:0] tgt,
                       input logic z, input logic n, input logic v,
                       input logic call, input logic ret);
    exp_t e;
    int   pp;
    int   nxt;
    bit   redir;
    @(negedge clk);
    rst = 0;
    bus.stall = stall; bus.hlt = hlt; bus.branch = branch; bus.cond = cond;
    bus.addr_src = addr_src; bus.imm = imm; bus.reg_target = tgt;
    bus.Z = z; bus.N = n; bus.V = v; bus.call = call; bus.ret = ret;

    pp    = (m_pc + 2) % 65536;
    nxt   = m_pc;
    redir = 0;
    if (m_halted || stall) begin
      nxt = m_pc;
    end else if (hlt) begin
      m_halted = 1;
    end else if (ret) begin
      redir = 1;
      if (m_ras.size() > 0) nxt = int'(m_ras.pop_back());
      else nxt = int'(tgt);
    end else if (branch && cond_ok(cond, z, n, v)) begin
      redir = 1;
      if (addr_src) nxt = int'(tgt);
      else nxt = (pp + 2 * int'($signed(imm)) + 65536 * 4) % 65536;
      if (call) begin
        m_ras.push_back(16'(pp));
        if (m_ras.size() > DEPTH) m_ras.delete(0);
      end
    end else begin
      nxt = pp;
    end

    e.is_rst   = 0;
    e.id       = txn_id;
    e.pc_plus  = 16'(pp);
    e.redirect = redir;
    e.pc       = 16'(nxt);
    e.halted   = m_halted;
    e.empty    = (m_ras.size() == 0);
    e.full     = (m_ras.size() == DEPTH);
    sb.push_back(e);
    txn_id++;
    m_pc = nxt;
  endtask

  // Assert reset half a period away from any rising edge; the monitor checks
  // the cleared state before the next edge arrives.
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst = 1;
    set_idle();
    m_pc = 0;
    m_halted = 0;
    m_ras.delete();
    e = '{is_rst: 1, id: txn_id, pc_plus: 16'h0002, redirect: 0, pc: 16'h0000,
          halted: 0, empty: 1, full: 0};
    sb.push_back(e);
    txn_id++;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 3'd0, 0, 9'd0, 16'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input logic [15:0] tgt, input logic call);
    cycle(0, 0, 1, 3'd7, 1, 9'd0, tgt, 0, 0, 0, call, 0);
  endtask

  task automatic ret_c(input logic [15:0] tgt);
    cycle(0, 0, 0, 3'd0, 0, 9'd0, tgt, 0, 0, 0, 0, 1);
  endtask

  task automatic rand_cycle(input int stall_pct, input int hlt_pct);
    cycle(logic'($urandom_range(99) < stall_pct), logic'($urandom_range(99) < hlt_pct),
          logic'($urandom_range(1)), 3'($urandom), logic'($urandom_range(1)),
          9'($urandom), 16'($urandom) & 16'hFFFE,
          logic'($urandom_range(1)), logic'($urandom_range(1)), logic'($urandom_range(1)),
          logic'($urandom_range(99) < 30), logic'($urandom_range(99) < 20));
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] got,
                     input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h expected=%h", name, id, got, expv);
    end
  endtask

  // Monitor: combinational outputs are sampled mid-low-phase, registered
  // outputs 1 time unit after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.is_rst) begin
          chk("rst_pc_out", e.id, 32'(bus.pc_out), 32'(e.pc));
          chk("rst_halted", e.id, 32'(bus.halted), 32'(e.halted));
          chk("rst_ras_empty", e.id, 32'(bus.ras_empty), 32'(e.empty));
          chk("rst_ras_full", e.id, 32'(bus.ras_full), 32'(e.full));
          $display("txn %0d: reset pc_out=%h halted=%b ras_empty=%b", e.id,
                   bus.pc_out, bus.halted, bus.ras_empty);
        end else begin
          chk("redirect", e.id, 32'(bus.redirect), 32'(e.redirect));
          chk("pc_plus", e.id, 32'(bus.pc_plus), 32'(e.pc_plus));
          @(posedge clk);
          #1;
          chk("pc_out", e.id, 32'(bus.pc_out), 32'(e.pc));
          chk("halted", e.id, 32'(bus.halted), 32'(e.halted));
          chk("ras_empty", e.id, 32'(bus.ras_empty), 32'(e.empty));
          chk("ras_full", e.id, 32'(bus.ras_full), 32'(e.full));
          $display("txn %0d: pc_out=%h halted=%b ras_empty=%b ras_full=%b", e.id,
                   bus.pc_out, bus.halted, bus.ras_empty, bus.ras_full);
        end
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog time limit reached with %0d expectations pending", sb.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst = 0;
    set_idle();
    #1 rst = 1;
    do_reset();

    // free-running from reset, up to PC 0x0010
    repeat (8) idle();

    // offset branch backwards: 0x0012 - 6 = 0x000C
    cycle(0, 0, 1, 3'b001, 0, 9'h1FD, 16'h0, 1, 0, 0, 0, 0);
    repeat (2) idle();
    // same branch not taken: 0x0012
    cycle(0, 0, 1, 3'b001, 0, 9'h1FD, 16'h0, 0, 0, 0, 0, 0);
    // forward offset wrapping past the top of the address space
    jump(16'hFFF0, 0);
    cycle(0, 0, 1, 3'b111, 0, 9'h0FF, 16'h0, 0, 0, 0, 0, 0);

    // condition sweep against a register target
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [2:0] fl;
        fl = 3'(f);
        cycle(0, 0, 1, 3'(c), 1, 9'd0, 16'h1234, fl[2], fl[1], fl[0], 0, 0);
      end
    end

    // RAS overflow: five calls from 0x100..0x500, then five returns
    jump(16'h0100, 0);
    jump(16'h0200, 1);
    jump(16'h0300, 1);
    jump(16'h0400, 1);
    jump(16'h0500, 1);
    jump(16'h0600, 1);
    repeat (4) ret_c(16'h0000);
    ret_c(16'hBEEF);

    // call, three stalled cycles with call/ret asserted, then ret
    jump(16'h0800, 0);
    jump(16'h0900, 1);
    repeat (3) cycle(1, 0, 1, 3'd7, 1, 9'd0, 16'h0A00, 0, 0, 0, 1, logic'($urandom_range(1)));
    ret_c(16'h0000);
    // call and ret together: ret wins, no push
    jump(16'h0C00, 1);
    cycle(0, 0, 1, 3'd7, 1, 9'd0, 16'h0D00, 0, 0, 0, 1, 1);

    // randomized traffic without halting
    repeat (300) rand_cycle(20, 0);

    // hlt under stall is dropped; then a call, then a real halt
    cycle(1, 1, 0, 3'd0, 0, 9'd0, 16'h0, 0, 0, 0, 0, 0);
    jump(16'h0E00, 1);
    cycle(0, 1, 1, 3'd7, 1, 9'd0, 16'h0F00, 0, 0, 0, 1, 0);
    repeat (10) rand_cycle(0, 50);

    // asynchronous reset while halted with live RAS entries
    do_reset();
    repeat (4) idle();
    repeat (40) rand_cycle(15, 3);

    repeat (3) @(negedge clk);
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
